// File: rtl/exc_deleg_trap_ctrl.sv
// Exception resolver and trap request register: picks the highest-priority raw
// exception, decides S vs M via the masked medeleg, and holds the request until acked.
module exc_deleg_trap_ctrl #(
    parameter int              XLEN       = 64,
    parameter int              NUM_EXC    = 16,
    parameter logic [XLEN-1:0] DELEG_MASK = 64'h0000_0000_0000_B3FF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         priv,
    input  logic               valid,
    input  logic [NUM_EXC-1:0] exc_vec,
    input  logic [XLEN-1:0]    exc_tval,
    input  logic [XLEN-1:0]    exc_pc,
    input  logic               flush,
    input  logic               csr_write,
    input  logic               mrw_medeleg_sel,
    input  logic [XLEN-1:0]    data_csr,
    output logic [XLEN-1:0]    medeleg,
    output logic               trap_valid,
    input  logic               trap_ack,
    output logic [XLEN-1:0]    trap_cause,
    output logic [XLEN-1:0]    trap_tval,
    output logic [XLEN-1:0]    trap_pc,
    output logic               trap_target_s,
    output logic               trap_target_m,
    output logic               exc_stall
);

    localparam int CW    = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
    localparam int NPRIO = 14;
    localparam int PRIO [NPRIO] = '{3, 12, 1, 2, 0, 9, 8, 11, 6, 4, 15, 13, 7, 5};
    localparam logic [NUM_EXC-1:0] ONE = 1;

    typedef enum logic {IDLE, PEND} state_t;

    state_t        state, state_nxt;
    logic          any_exc, cap_req, load;
    logic [CW-1:0] win;
    logic          win_s;
    logic          unused_priv;

    assign unused_priv = ^priv[2:0];
    assign any_exc     = valid & (|exc_vec);
    assign cap_req     = any_exc & ~flush;

    // Fixed priority list first, then any remaining bit lowest-index first.
    always_comb begin : prio
        logic               found;
        logic [NUM_EXC-1:0] sh;
        found = 1'b0;
        win   = '0;
        sh    = '0;
        for (int k = 0; k < NPRIO; k++) begin
            if (PRIO[k] < NUM_EXC) begin
                sh = exc_vec >> PRIO[k];
                if (!found && sh[0]) begin
                    win   = CW'(PRIO[k]);
                    found = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_EXC; i++) begin
            sh = exc_vec >> i;
            if (!found && sh[0]) begin
                win   = CW'(i);
                found = 1'b1;
            end
        end
    end

    // Uses the pre-write medeleg, so a same-cycle CSR write does not affect capture.
    assign win_s = ~priv[3] & (|(medeleg[NUM_EXC-1:0] & (ONE << win)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cap_req) state_nxt = PEND;
            PEND: begin
                if (flush)         state_nxt = IDLE;
                else if (trap_ack) state_nxt = cap_req ? PEND : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        trap_valid = (state == PEND);
        load       = cap_req & ((state == IDLE) | trap_ack);
        exc_stall  = (state == PEND) & any_exc & ~trap_ack;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap_cause    <= '0;
            trap_tval     <= '0;
            trap_pc       <= '0;
            trap_target_s <= 1'b0;
            trap_target_m <= 1'b0;
        end else if (load) begin
            trap_cause    <= XLEN'(win);
            trap_tval     <= exc_tval;
            trap_pc       <= exc_pc;
            trap_target_s <= win_s;
            trap_target_m <= ~win_s;
        end else if (state_nxt == IDLE) begin
            trap_target_s <= 1'b0;
            trap_target_m <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               medeleg <= '0;
        else if (csr_write && mrw_medeleg_sel)  medeleg <= data_csr & DELEG_MASK;
    end

endmodule

// File: tb/tb_exc_deleg_trap_ctrl.sv
// Randomised bench for exc_deleg_trap_ctrl checked every cycle against a
// transaction-level model, plus directed cases with literal expectations.
module tb_exc_deleg_trap_ctrl;

    localparam int          XLEN    = 64;
    localparam int          NUM_EXC = 16;
    localparam logic [63:0] MASK    = 64'h0000_0000_0000_B3FF;

    logic               clk, rst;
    logic [3:0]         priv;
    logic               valid;
    logic [NUM_EXC-1:0] exc_vec;
    logic [XLEN-1:0]    exc_tval, exc_pc;
    logic               flush, csr_write, mrw_medeleg_sel;
    logic [XLEN-1:0]    data_csr;
    logic [XLEN-1:0]    medeleg;
    logic               trap_valid, trap_ack;
    logic [XLEN-1:0]    trap_cause, trap_tval, trap_pc;
    logic               trap_target_s, trap_target_m, exc_stall;

    exc_deleg_trap_ctrl #(.XLEN(XLEN), .NUM_EXC(NUM_EXC), .DELEG_MASK(MASK)) dut (
        .clk(clk), .rst(rst), .priv(priv), .valid(valid), .exc_vec(exc_vec),
        .exc_tval(exc_tval), .exc_pc(exc_pc), .flush(flush), .csr_write(csr_write),
        .mrw_medeleg_sel(mrw_medeleg_sel), .data_csr(data_csr), .medeleg(medeleg),
        .trap_valid(trap_valid), .trap_ack(trap_ack), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .trap_pc(trap_pc), .trap_target_s(trap_target_s),
        .trap_target_m(trap_target_m), .exc_stall(exc_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state
    logic [63:0] m_medeleg, m_cause, m_tval, m_pc;
    bit          m_valid, m_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [NUM_EXC-1:0] v);
        int order [14] = '{3, 12, 1, 2, 0, 9, 8, 11, 6, 4, 15, 13, 7, 5};
        logic [NUM_EXC-1:0] t;
        foreach (order[k]) begin
            t = v >> order[k];
            if (order[k] < NUM_EXC && t[0]) return order[k];
        end
        for (int i = 0; i < NUM_EXC; i++) begin
            t = v >> i;
            if (t[0]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_medeleg = '0; m_cause = '0; m_tval = '0; m_pc = '0;
        m_valid = 1'b0; m_s = 1'b0;
    endtask

    task automatic model_capture();
        int w;
        w         = winner(exc_vec);
        m_cause   = 64'(w);
        m_s       = !priv[3] && (((m_medeleg >> w) & 64'd1) != 0);
        m_tval    = exc_tval;
        m_pc      = exc_pc;
        m_valid   = 1'b1;
    endtask

    task automatic model_step();
        bit cap;
        cap = valid && (exc_vec != 0) && !flush;
        if (!m_valid) begin
            if (cap) model_capture();
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (trap_ack) begin
            if (cap) model_capture();
            else     m_valid = 1'b0;
        end
        if (csr_write && mrw_medeleg_sel) m_medeleg = data_csr & MASK;
    endtask

    task automatic check_all();
        chk("medeleg", medeleg, m_medeleg);
        chk("trap_valid", 64'(trap_valid), 64'(m_valid));
        chk("target_s", 64'(trap_target_s), 64'(m_valid && m_s));
        chk("target_m", 64'(trap_target_m), 64'(m_valid && !m_s));
        chk("exc_stall", 64'(exc_stall), 64'(m_valid && valid && (exc_vec != 0) && !trap_ack));
        if (m_valid) begin
            chk("trap_cause", trap_cause, m_cause);
            chk("trap_tval", trap_tval, m_tval);
            chk("trap_pc", trap_pc, m_pc);
        end
    endtask

    task automatic idle_in();
        valid = 1'b0; exc_vec = '0; flush = 1'b0; trap_ack = 1'b0;
        csr_write = 1'b0; mrw_medeleg_sel = 1'b0; data_csr = '0;
    endtask

    // inputs are driven at negedge; check, clock, advance model, return at next negedge
    task automatic tick();
        #1 check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [63:0] d);
        idle_in();
        csr_write = 1'b1; mrw_medeleg_sel = 1'b1; data_csr = d;
        tick();
        idle_in();
    endtask

    task automatic exc(input logic [3:0] p, input logic [NUM_EXC-1:0] v);
        idle_in();
        priv = p; valid = 1'b1; exc_vec = v;
        exc_tval = {$urandom, $urandom}; exc_pc = {$urandom, $urandom};
        tick();
        idle_in();
    endtask

    task automatic ack_it();
        idle_in();
        trap_ack = 1'b1;
        tick();
        idle_in();
    endtask

    initial begin
        logic [NUM_EXC-1:0] one;
        logic [NUM_EXC-1:0] v;
        one = 1;
        rst = 1'b0; priv = 4'b0001; exc_tval = '0; exc_pc = '0;
        idle_in();
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst medeleg", medeleg, 64'h0);
        chk("rst trap_valid", 64'(trap_valid), 64'h0);
        chk("rst cause", trap_cause, 64'h0);
        chk("rst tval", trap_tval, 64'h0);
        chk("rst pc", trap_pc, 64'h0);
        chk("rst s", 64'(trap_target_s), 64'h0);
        chk("rst m", 64'(trap_target_m), 64'h0);
        chk("rst stall", 64'(exc_stall), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        wr(64'hFFFF_FFFF_FFFF_FFFF);
        chk("medeleg mask", medeleg, 64'hB3FF);

        wr(64'h100);
        exc(4'b0001, 16'h0100);
        chk("U deleg valid", 64'(trap_valid), 64'h1);
        chk("U deleg cause", trap_cause, 64'd8);
        chk("U deleg s", 64'(trap_target_s), 64'h1);
        ack_it();
        chk("ack clears", 64'(trap_valid), 64'h0);
        exc(4'b1000, 16'h0100);
        chk("M no deleg m", 64'(trap_target_m), 64'h1);
        chk("M no deleg s", 64'(trap_target_s), 64'h0);
        ack_it();

        exc(4'b0001, 16'h1028);
        chk("prio 3", trap_cause, 64'd3);
        ack_it();
        exc(4'b0001, 16'h1020);
        chk("prio 12", trap_cause, 64'd12);
        ack_it();

        wr(64'hFFFF_FFFF_FFFF_FFFF);
        exc(4'b0010, 16'h0800);
        chk("ecall M cause", trap_cause, 64'd11);
        chk("ecall M target", 64'(trap_target_m), 64'h1);

        idle_in(); priv = 4'b0010; valid = 1'b1; exc_vec = 16'h0010;
        #1 chk("stall asserted", 64'(exc_stall), 64'h1);
        tick();
        chk("stall hold cause", trap_cause, 64'd11);
        idle_in(); valid = 1'b1; exc_vec = 16'h0010; trap_ack = 1'b1;
        exc_tval = 64'h1234; exc_pc = 64'h8000_0000;
        #1 chk("ack no stall", 64'(exc_stall), 64'h0);
        tick();
        chk("b2b valid", 64'(trap_valid), 64'h1);
        chk("b2b cause", trap_cause, 64'd4);
        chk("b2b pc", trap_pc, 64'h8000_0000);
        chk("b2b s", 64'(trap_target_s), 64'h1);
        idle_in(); flush = 1'b1;
        tick();
        chk("flush clears", 64'(trap_valid), 64'h0);
        idle_in();

        exc(4'b0001, 16'h0004);
        chk("pend before rst", 64'(trap_valid), 64'h1);
        #2 rst = 1'b0;
        #1;
        chk("async rst valid", 64'(trap_valid), 64'h0);
        chk("async rst cause", trap_cause, 64'h0);
        chk("async rst medeleg", medeleg, 64'h0);
        chk("async rst s", 64'(trap_target_s), 64'h0);
        chk("async rst m", 64'(trap_target_m), 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_in();

        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(2, 0))
                0:       priv = 4'b0001;
                1:       priv = 4'b0010;
                default: priv = 4'b1000;
            endcase
            valid = ($urandom_range(9, 0) < 7);
            v = '0;
            if ($urandom_range(9, 0) >= 3) begin
                for (int j = 0; j <= int'($urandom_range(2, 0)); j++)
                    v |= one << $urandom_range(NUM_EXC - 1, 0);
            end
            exc_vec         = v;
            exc_tval        = {$urandom, $urandom};
            exc_pc          = {$urandom, $urandom};
            flush           = ($urandom_range(9, 0) == 0);
            trap_ack        = ($urandom_range(9, 0) < 4);
            csr_write       = ($urandom_range(19, 0) < 3);
            mrw_medeleg_sel = ($urandom_range(1, 0) == 1);
            data_csr        = {$urandom, $urandom};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
